id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the RV64 pipeline, successor to the fixed-width ID/EX latch.
- Adds valid/ready handshake, synchronous flush, automatic bubble insertion on load-use hazards, and a saturating stall counter.
- Sits between the decode stage (upstream) and the execute stage (downstream).

Parameters:
- XLEN, 64, width of register data and immediate.
- REG_AW, 5, register index width.
- ALUOP_W, 2, ALU op field width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of every held instruction.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in  in  1 each  control bits.
- alu_op_in  in  ALUOP_W  ALU op.
- rs1_data_in, rs2_data_in, imm_in  in  XLEN each  operands and immediate.
- rs1_idx_in, rs2_idx_in, rd_idx_in  in  REG_AW each  register indices.
- out_valid  out  1  execute sees a real instruction.
- out_ready  in  1  execute consumes this cycle.
- alu_src_out ... imm_out  out  same widths  registered copies of every _in field.
- load_use_hazard  out  1  combinational hazard flag.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, all control outputs=0, data/index outputs=0, stall_cnt=0.
- Handshake:
  - accept = in_valid & in_ready; advance = out_ready | ~out_valid.
  - Without skid: in_ready = advance & ~load_use_hazard.
  - On accept: all _in fields load into the output registers; out_valid=1 at the next edge. Latency is 1 cycle.
  - On advance without accept: out_valid=0 (bubble).
  - Otherwise: all outputs hold.
- Bubble rule: whenever out_valid=0, reg_write_out, mem_read_out and mem_write_out must read 0. Data fields may hold stale values.
- Load-use hazard: load_use_hazard = in_valid & out_valid & mem_read_out & (rd_idx_out != 0) & (rd_idx_out == rs1_idx_in | rd_idx_out == rs2_idx_in).
  - While the hazard holds, the stage refuses input. When execute consumes the load, a bubble enters and the hazard clears the following cycle.
  - Result: exactly one bubble per load-use pair when out_ready=1.
- Flush has priority over accept and advance.
  - Next edge: out_valid=0, control bits cleared, skid entry invalidated.
  - in_ready is still reported but the accepted instruction is dropped.
  - Decode treats a flush-cycle accept as killed.
- stall_cnt: increments by 1 on every cycle where in_valid & ~in_ready & ~flush. Saturates at all-ones; no wrap. Only reset clears it.
- rd_idx_in = 0 never causes a hazard.

Optional Feature:
- Macro: ID_EX_SKID_EN.
- Defined:
  - A one-entry skid buffer is added; in_ready = ~skid_valid & ~load_use_hazard, so out_ready no longer reaches in_ready combinationally.
  - An instruction accepted while advance=0 goes to the skid buffer; the skid drains into the output register on the next advance.
  - Hazard comparison uses the skid entry when skid_valid=1, otherwise the output register.
  - Flush clears both entries.
  - Throughput stays 1 per cycle in steady state.
- Undefined: no skid buffer; behaviour exactly as above.

Decomposition:
- Package id_ex_pkg holds:
  - typedef id_ex_ctrl_t, a struct of the five control bits plus alu_op;
  - typedef id_ex_data_t, operands, indices and immediate;
  - constant ZERO_REG = 0;
  - a function computing the hazard compare.
- Sub-module id_ex_skid_buf holds the one-entry buffer; it is instantiated only under ID_EX_SKID_EN.

Test Plan:
- Reset mid-run: drive rst=0 while out_valid=1 -> all outputs 0 immediately (asynchronous), stall_cnt=0.
- Pass-through: in_valid=1, out_ready=1, rs1_data_in=64'hDEAD_BEEF_0000_0001, rd_idx_in=5 -> next cycle out_valid=1, rs1_data_out matches, rd_idx_out=5.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs hold, in_ready=0, stall_cnt=3. With ID_EX_SKID_EN, in_ready=1 on the first cycle, then 0, and stall_cnt=2.
- Load-use: load with rd=7 in the register, next instruction has rs2_idx_in=7, out_ready=1 -> load_use_hazard=1 for one cycle, one bubble with reg_write_out=0, then the instruction issues. The same case with rd=0 -> no hazard.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, mem_write_out=0, dropped instruction never appears.
- Saturation: CNT_W=4, force 20 stalled cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/id_ex_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pkg
//   Shared types and helpers for the ID/EX pipeline register.
//   - id_ex_ctrl_t : the five control bits plus the ALU op field
//   - id_ex_data_t : operands, immediate and register indices
//   - ZERO_REG     : x0, which never creates a dependency
//   - load_use_match() : hazard compare of a held load against decode sources
//   - bubble_ctrl()    : strips the architecturally visible side effects
//   The struct field widths come from the ID_EX_* constants below; the
//   module parameters of id_ex_pipe_reg default to these and must match them.
// -----------------------------------------------------------------------------
package id_ex_pkg;

  localparam int unsigned ID_EX_XLEN    = 64;
  localparam int unsigned ID_EX_REG_AW  = 5;
  localparam int unsigned ID_EX_ALUOP_W = 2;

  localparam logic [ID_EX_REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                     alu_src;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic [ID_EX_ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [ID_EX_XLEN-1:0]   rs1_data;
    logic [ID_EX_XLEN-1:0]   rs2_data;
    logic [ID_EX_XLEN-1:0]   imm;
    logic [ID_EX_REG_AW-1:0] rs1_idx;
    logic [ID_EX_REG_AW-1:0] rs2_idx;
    logic [ID_EX_REG_AW-1:0] rd_idx;
  } id_ex_data_t;

  // True when a held load writes a register the incoming instruction reads.
  // Writes to x0 are discarded by the register file, so they never match.
  function automatic logic load_use_match(
    input logic                    mem_read,
    input logic [ID_EX_REG_AW-1:0] rd_idx,
    input logic [ID_EX_REG_AW-1:0] rs1_idx,
    input logic [ID_EX_REG_AW-1:0] rs2_idx
  );
    return mem_read && (rd_idx != ZERO_REG) &&
           ((rd_idx == rs1_idx) || (rd_idx == rs2_idx));
  endfunction

  // A bubble must not write the register file or touch memory; the
  // remaining control fields are don't-care and are left as they were.
  function automatic id_ex_ctrl_t bubble_ctrl(input id_ex_ctrl_t ctrl);
    id_ex_ctrl_t res;
    res           = ctrl;
    res.reg_write = 1'b0;
    res.mem_read  = 1'b0;
    res.mem_write = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/id_ex_skid_buf.sv
// -----------------------------------------------------------------------------
// id_ex_skid_buf
//   One-entry skid buffer used by id_ex_pipe_reg when ID_EX_SKID_EN is
//   defined. Catches an instruction accepted while execute is stalled so
//   that in_ready can be registered instead of following out_ready.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous invalidate of the held entry
//   push_i          capture data_i (caller guarantees the entry is free)
//   pop_i           release the entry (caller guarantees it is valid)
//   data_i          packed instruction to capture
//   valid_o/data_o  held entry
// -----------------------------------------------------------------------------
module id_ex_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; valid_q qualifies it, so resetting it
  // would only add reset fan-out to a wide register.
  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register with valid/ready handshake, synchronous flush,
//   automatic bubble on load-use hazards and a saturating stall counter.
//   Optional build macro: ID_EX_SKID_EN adds a one-entry skid buffer so that
//   in_ready no longer depends combinationally on out_ready.
// Ports:
//   clk, rst (async, active-low), flush
//   in_valid / in_ready          decode-side handshake
//   *_in                         control bits, ALU op, operands, indices
//   out_valid / out_ready        execute-side handshake
//   *_out                        registered copies of every *_in field
//   load_use_hazard              combinational hazard flag
//   stall_cnt                    saturating count of stalled decode cycles
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned XLEN    = ID_EX_XLEN,
  parameter int unsigned REG_AW  = ID_EX_REG_AW,
  parameter int unsigned ALUOP_W = ID_EX_ALUOP_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_src_in,
  input  logic               mem_to_reg_in,
  input  logic               reg_write_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [ALUOP_W-1:0] alu_op_in,
  input  logic [XLEN-1:0]    rs1_data_in,
  input  logic [XLEN-1:0]    rs2_data_in,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [REG_AW-1:0]  rs1_idx_in,
  input  logic [REG_AW-1:0]  rs2_idx_in,
  input  logic [REG_AW-1:0]  rd_idx_in,

  output logic               out_valid,
  input  logic               out_ready,
  output logic               alu_src_out,
  output logic               mem_to_reg_out,
  output logic               reg_write_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic [ALUOP_W-1:0] alu_op_out,
  output logic [XLEN-1:0]    rs1_data_out,
  output logic [XLEN-1:0]    rs2_data_out,
  output logic [XLEN-1:0]    imm_out,
  output logic [REG_AW-1:0]  rs1_idx_out,
  output logic [REG_AW-1:0]  rs2_idx_out,
  output logic [REG_AW-1:0]  rd_idx_out,

  output logic               load_use_hazard,
  output logic [CNT_W-1:0]   stall_cnt
);

  id_ex_ctrl_t      ctrl_in;
  id_ex_data_t      data_in;

  logic             out_valid_q, out_valid_d;
  id_ex_ctrl_t      ctrl_q, ctrl_d;
  id_ex_data_t      data_q, data_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             advance;
  logic             accept;
  logic             hazard;
  logic             in_ready_w;

  assign ctrl_in = '{alu_src:    alu_src_in,
                     mem_to_reg: mem_to_reg_in,
                     reg_write:  reg_write_in,
                     mem_read:   mem_read_in,
                     mem_write:  mem_write_in,
                     alu_op:     alu_op_in};

  assign data_in = '{rs1_data: rs1_data_in,
                     rs2_data: rs2_data_in,
                     imm:      imm_in,
                     rs1_idx:  rs1_idx_in,
                     rs2_idx:  rs2_idx_in,
                     rd_idx:   rd_idx_in};

  // The output register can take a new value when it is empty or when
  // execute consumes what it holds this cycle.
  assign advance = out_ready | ~out_valid_q;
  assign accept  = in_valid & in_ready_w;

`ifdef ID_EX_SKID_EN
  localparam int unsigned ENTRY_W = $bits(id_ex_ctrl_t) + $bits(id_ex_data_t);

  logic               skid_valid;
  logic               skid_push;
  logic               skid_pop;
  logic [ENTRY_W-1:0] skid_entry;
  id_ex_ctrl_t        skid_ctrl;
  id_ex_data_t        skid_data;

  // An instruction accepted while execute stalls parks in the skid entry;
  // the entry drains into the output register on the next advance.
  assign skid_push = accept & ~advance & ~flush;
  assign skid_pop  = skid_valid & advance & ~flush;

  id_ex_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  ({ctrl_in, data_in}),
    .valid_o (skid_valid),
    .data_o  (skid_entry)
  );

  assign {skid_ctrl, skid_data} = skid_entry;

  // The youngest held instruction is the one the incoming one depends on:
  // the skid entry when occupied, otherwise the output register.
  assign hazard = in_valid &
                  (skid_valid ? load_use_match(skid_ctrl.mem_read, skid_data.rd_idx,
                                               rs1_idx_in, rs2_idx_in)
                              : out_valid_q &
                                load_use_match(ctrl_q.mem_read, data_q.rd_idx,
                                               rs1_idx_in, rs2_idx_in));

  assign in_ready_w = ~skid_valid & ~hazard;
`else
  assign hazard = in_valid & out_valid_q &
                  load_use_match(ctrl_q.mem_read, data_q.rd_idx,
                                 rs1_idx_in, rs2_idx_in);

  // Refusing input while the load sits in the output register lets the
  // next advance insert exactly one bubble ahead of the dependent op.
  assign in_ready_w = advance & ~hazard;
`endif

  // NOTE: every variable gets its hold value first so no path through the
  // if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;

    if (flush) begin
      // Flush wins over everything; data fields may keep stale values.
      out_valid_d = 1'b0;
      ctrl_d      = '0;
`ifdef ID_EX_SKID_EN
    end else if (skid_pop) begin
      out_valid_d = 1'b1;
      ctrl_d      = skid_ctrl;
      data_d      = skid_data;
`endif
    end else if (accept && advance) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl_in;
      data_d      = data_in;
    end else if (advance) begin
      // Bubble: side-effect bits must read 0 whenever out_valid is 0.
      out_valid_d = 1'b0;
      ctrl_d      = bubble_ctrl(ctrl_q);
    end
  end

  // Counts decode cycles lost to back-pressure or hazards; sticks at
  // all-ones and is cleared only by reset.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready_w && !flush && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready        = in_ready_w;
  assign load_use_hazard = hazard;
  assign stall_cnt       = stall_q;

  assign out_valid       = out_valid_q;
  assign alu_src_out     = ctrl_q.alu_src;
  assign mem_to_reg_out  = ctrl_q.mem_to_reg;
  assign reg_write_out   = ctrl_q.reg_write;
  assign mem_read_out    = ctrl_q.mem_read;
  assign mem_write_out   = ctrl_q.mem_write;
  assign alu_op_out      = ctrl_q.alu_op;
  assign rs1_data_out    = data_q.rs1_data;
  assign rs2_data_out    = data_q.rs2_data;
  assign imm_out         = data_q.imm;
  assign rs1_idx_out     = data_q.rs1_idx;
  assign rs2_idx_out     = data_q.rs2_idx;
  assign rd_idx_out      = data_q.rd_idx;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//   Directed bench for id_ex_pipe_reg (CNT_W = 4). Expected instructions are
//   queued when driven and compared when they reach the output register.
//   Expectations follow ID_EX_SKID_EN where the two builds differ.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
  import id_ex_pkg::*;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    id_ex_ctrl_t c;
    id_ex_data_t d;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
  logic [1:0]       alu_op_in;
  logic [63:0]      rs1_data_in, rs2_data_in, imm_in;
  logic [4:0]       rs1_idx_in, rs2_idx_in, rd_idx_in;
  logic             out_valid;
  logic             out_ready;
  logic             alu_src_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
  logic [1:0]       alu_op_out;
  logic [63:0]      rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]       rs1_idx_out, rs2_idx_out, rd_idx_out;
  logic             load_use_hazard;
  logic [CNT_W-1:0] stall_cnt;

  int   n_err = 0;
  int   n_chk = 0;
  int   exp_cnt = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_src_in      (alu_src_in),
    .mem_to_reg_in   (mem_to_reg_in),
    .reg_write_in    (reg_write_in),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .alu_op_in       (alu_op_in),
    .rs1_data_in     (rs1_data_in),
    .rs2_data_in     (rs2_data_in),
    .imm_in          (imm_in),
    .rs1_idx_in      (rs1_idx_in),
    .rs2_idx_in      (rs2_idx_in),
    .rd_idx_in       (rd_idx_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_src_out     (alu_src_out),
    .mem_to_reg_out  (mem_to_reg_out),
    .reg_write_out   (reg_write_out),
    .mem_read_out    (mem_read_out),
    .mem_write_out   (mem_write_out),
    .alu_op_out      (alu_op_out),
    .rs1_data_out    (rs1_data_out),
    .rs2_data_out    (rs2_data_out),
    .imm_out         (imm_out),
    .rs1_idx_out     (rs1_idx_out),
    .rs2_idx_out     (rs2_idx_out),
    .rd_idx_out      (rd_idx_out),
    .load_use_hazard (load_use_hazard),
    .stall_cnt       (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cbits = {alu_src, mem_to_reg, reg_write, mem_read, mem_write}
  function automatic txn_t mk(input logic [4:0] cbits, input logic [1:0] op,
                              input logic [63:0] r1, input logic [63:0] r2,
                              input logic [63:0] im, input logic [4:0] i1,
                              input logic [4:0] i2, input logic [4:0] rd);
    txn_t t;
    t.c = id_ex_ctrl_t'({cbits, op});
    t.d = '{rs1_data: r1, rs2_data: r2, imm: im, rs1_idx: i1, rs2_idx: i2, rd_idx: rd};
    return t;
  endfunction

  task automatic drive(input txn_t t, input logic v);
    in_valid      = v;
    alu_src_in    = t.c.alu_src;
    mem_to_reg_in = t.c.mem_to_reg;
    reg_write_in  = t.c.reg_write;
    mem_read_in   = t.c.mem_read;
    mem_write_in  = t.c.mem_write;
    alu_op_in     = t.c.alu_op;
    rs1_data_in   = t.d.rs1_data;
    rs2_data_in   = t.d.rs2_data;
    imm_in        = t.d.imm;
    rs1_idx_in    = t.d.rs1_idx;
    rs2_idx_in    = t.d.rs2_idx;
    rd_idx_in     = t.d.rd_idx;
  endtask

  task automatic check_out(input string tag);
    txn_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ctrl"}, 64'({alu_src_out, mem_to_reg_out, reg_write_out,
                               mem_read_out, mem_write_out, alu_op_out}), 64'(e.c));
    check({tag, "_rs1"}, rs1_data_out, e.d.rs1_data);
    check({tag, "_rs2"}, rs2_data_out, e.d.rs2_data);
    check({tag, "_imm"}, imm_out, e.d.imm);
    check({tag, "_idx"}, 64'({rs1_idx_out, rs2_idx_out, rd_idx_out}),
          64'({e.d.rs1_idx, e.d.rs2_idx, e.d.rd_idx}));
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    txn_t t_a, t_b, t_c, t_l, t_d, t_l0, t_e, t_f, t_g, t_h, t_i, t_j;
    logic exp_rdy;

    t_a  = mk(5'b00100, 2'd2, 64'hDEAD_BEEF_0000_0001, 64'h22, 64'h33, 5'd1, 5'd2, 5'd5);
    t_b  = mk(5'b10100, 2'd1, 64'hB1, 64'hB2, 64'hB3, 5'd3, 5'd4, 5'd10);
    t_c  = mk(5'b00100, 2'd3, 64'hC1, 64'hC2, 64'hC3, 5'd5, 5'd6, 5'd11);
    t_l  = mk(5'b01110, 2'd0, 64'h1000, 64'h0, 64'h8, 5'd1, 5'd2, 5'd7);
    t_d  = mk(5'b00100, 2'd0, 64'hD1, 64'hD2, 64'hD3, 5'd3, 5'd7, 5'd9);
    t_l0 = mk(5'b01110, 2'd0, 64'h2000, 64'h0, 64'h10, 5'd4, 5'd5, 5'd0);
    t_e  = mk(5'b00100, 2'd1, 64'hE1, 64'hE2, 64'hE3, 5'd0, 5'd0, 5'd12);
    t_f  = mk(5'b10001, 2'd0, 64'hF1, 64'hF2, 64'hF3, 5'd8, 5'd9, 5'd13);
    t_g  = mk(5'b00100, 2'd2, 64'h6666, 64'h67, 64'h68, 5'd10, 5'd11, 5'd14);
    t_h  = mk(5'b00100, 2'd1, 64'h1234, 64'h35, 64'h36, 5'd12, 5'd13, 5'd15);
    t_i  = mk(5'b00100, 2'd3, 64'h4321, 64'h44, 64'h45, 5'd14, 5'd15, 5'd16);
    t_j  = mk(5'b00110, 2'd2, 64'hFACE, 64'hCAFE, 64'h7, 5'd17, 5'd18, 5'd19);

    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(t_a, 1'b0);

    // Reset state
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    check("rst_ctrl", 64'({reg_write_out, mem_read_out, mem_write_out}), 64'd0);
    check("rst_rs1", rs1_data_out, 64'd0);
    check("rst_rd", 64'(rd_idx_out), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Pass-through, 1-cycle latency
    drive(t_a, 1'b1);
    out_ready = 1'b1;
    sample();
    check("pt_ready", 64'(in_ready), 64'd1);
    check("pt_hazard", 64'(load_use_hazard), 64'd0);
    sb.push_back(t_a);
    next();
    in_valid = 1'b0;
    sample();
    check_out("pt");
    next();
    sample();
    check("pt_bubble_valid", 64'(out_valid), 64'd0);
    check("pt_bubble_rw", 64'(reg_write_out), 64'd0);
    check("pt_cnt", 64'(stall_cnt), 64'(exp_cnt));
    next();

    // Back-pressure: three cycles of out_ready = 0 with input waiting
    drive(t_b, 1'b1);
    sample();
    sb.push_back(t_b);
    next();
    drive(t_c, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
`ifdef ID_EX_SKID_EN
      exp_rdy = (i == 0);
`else
      exp_rdy = 1'b0;
`endif
      check($sformatf("bp_ready%0d", i), 64'(in_ready), 64'(exp_rdy));
      if (i == 0) begin
        check_out("bp_hold0");
        if (exp_rdy) sb.push_back(t_c);
      end else begin
        check($sformatf("bp_hold%0d_rd", i), 64'(rd_idx_out), 64'd10);
        check($sformatf("bp_hold%0d_v", i), 64'(out_valid), 64'd1);
      end
      if (!exp_rdy) exp_cnt++;
      next();
    end
    out_ready = 1'b1;
`ifdef ID_EX_SKID_EN
    in_valid = 1'b0;
    sample();
    check("bp_cnt", 64'(stall_cnt), 64'(exp_cnt));
`else
    sample();
    check("bp_cnt", 64'(stall_cnt), 64'(exp_cnt));
    check("bp_ready_resume", 64'(in_ready), 64'd1);
    sb.push_back(t_c);
`endif
    next();
    in_valid = 1'b0;
    sample();
    check_out("bp_drain");
    next();

    // Load-use with rd = 7: exactly one bubble
    drive(t_l, 1'b1);
    sample();
    check("lu_ready_ld", 64'(in_ready), 64'd1);
    sb.push_back(t_l);
    next();
    drive(t_d, 1'b1);
    sample();
    check_out("lu_load");
    check("lu_hazard", 64'(load_use_hazard), 64'd1);
    check("lu_ready", 64'(in_ready), 64'd0);
    exp_cnt++;
    next();
    sample();
    check("lu_bubble_valid", 64'(out_valid), 64'd0);
    check("lu_bubble_side", 64'({reg_write_out, mem_read_out, mem_write_out}), 64'd0);
    check("lu_hazard_clr", 64'(load_use_hazard), 64'd0);
    check("lu_ready_clr", 64'(in_ready), 64'd1);
    sb.push_back(t_d);
    next();
    in_valid = 1'b0;
    sample();
    check_out("lu_issue");
    check("lu_cnt", 64'(stall_cnt), 64'(exp_cnt));
    next();

    // Load to x0 never creates a hazard
    drive(t_l0, 1'b1);
    sample();
    sb.push_back(t_l0);
    next();
    drive(t_e, 1'b1);
    sample();
    check_out("x0_load");
    check("x0_hazard", 64'(load_use_hazard), 64'd0);
    check("x0_ready", 64'(in_ready), 64'd1);
    sb.push_back(t_e);
    next();
    in_valid = 1'b0;
    sample();
    check_out("x0_issue");
    next();

    // Flush with a valid instruction held and another being accepted
    drive(t_f, 1'b1);
    sample();
    sb.push_back(t_f);
    next();
    drive(t_g, 1'b1);
    flush = 1'b1;
    sample();
    check_out("fl_held");
    check("fl_ready", 64'(in_ready), 64'd1);
    next();
    flush = 1'b0;
    in_valid = 1'b0;
    sample();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_mem_write", 64'(mem_write_out), 64'd0);
    check("fl_reg_write", 64'(reg_write_out), 64'd0);
    check("fl_cnt", 64'(stall_cnt), 64'(exp_cnt));
    next();
    sample();
    check("fl_dropped", 64'(out_valid), 64'd0);
    check("fl_sb_empty", 64'(sb.size()), 64'd0);
    next();

    // Counter saturation: 20 stalled cycles on a 4-bit counter
    drive(t_h, 1'b1);
    out_ready = 1'b1;
    sample();
    sb.push_back(t_h);
    next();
    drive(t_i, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (i == 0) check_out("sat_hold");
      next();
    end
    sample();
    check("sat_cnt", 64'(stall_cnt), 64'd15);
    next();
    sample();
    check("sat_cnt_hold", 64'(stall_cnt), 64'd15);
    check("sat_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-cycle while out_valid = 1
    next();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt", 64'(stall_cnt), 64'd0);
    check("arst_rs1", rs1_data_out, 64'd0);
    check("arst_rd", 64'(rd_idx_out), 64'd0);
    check("arst_ctrl", 64'({reg_write_out, mem_read_out, mem_write_out}), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst = 1'b1;

    // Operation resumes after reset
    next();
    drive(t_j, 1'b1);
    sample();
    check("post_ready", 64'(in_ready), 64'd1);
    sb.push_back(t_j);
    next();
    in_valid = 1'b0;
    sample();
    check_out("post");
    check("post_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time limit in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
